// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge_pkg
// Description : Shared types, constants and helpers for the CPU-to-memory
//               bridge (state encoding, abort fill values, word alignment).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

   // Bridge sequencing states: data access is always tried before the fetch
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_INSTR = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Value returned to the core when a fetch is aborted: ADDI x0,x0,0
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   // Value returned to the core when a load is aborted
   localparam logic [31:0] ABORT_DATA = 32'h0000_0000;

   // Widest address the alignment helper accepts; callers cast in and out
   localparam int ADDR_MAX_W = 64;

   // Clear the byte offset so the memory always sees a word address
   function automatic logic [ADDR_MAX_W-1:0] word_align(input logic [ADDR_MAX_W-1:0] addr);
      word_align = {addr[ADDR_MAX_W-1:2], 2'b00};
   endfunction

endpackage : mem_bridge_pkg
`default_nettype wire

// File: rtl/mem_bridge_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge_timer
// Description : Access watchdog. Counts cycles while enabled, clears on
//               request, and flags expiry in the TIMEOUT_CYC-th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge_timer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic rst,        // asynchronous, active-low
   input  logic clr_i,      // return count to zero
   input  logic en_i,       // an access is in progress
   output logic expire_o    // last permitted wait cycle reached
);

   // Counter only needs to hold 0 .. TIMEOUT_CYC-1
   localparam int CNT_W = ($clog2(TIMEOUT_CYC) < 1) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign expire_o = en_i & (count_q == CNT_LAST);

   // Next count: clear wins, otherwise advance until the last value
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != CNT_LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : mem_bridge_timer
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mem_bridge
// Description : Serialises the core's data and instruction requests onto a
//               single-ported variable-latency memory (data first), stalls
//               the core meanwhile and returns registered read data. A
//               watchdog aborts stuck accesses and raises a sticky bus_err.
//               Optional performance counters: define MEM_BRIDGE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst,          // asynchronous, active-low
   // core side
   input  logic              instr_read,
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic              data_read,
   input  logic [3:0]        data_write,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_in,
   output logic [31:0]       instr_out,
   output logic [31:0]       data_out,
   output logic              cpu_stall,
   // memory side
   output logic              mem_req,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   // status
   output logic              bus_err
`ifdef MEM_BRIDGE_PERF_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_access_cnt
`endif
);

   // ------------------------------------------------------------------------
   // State and captured data
   // ------------------------------------------------------------------------
   state_e      state_q, state_d;
   logic        d_done_q, d_done_d;   // data part of this CPU cycle finished
   logic        i_done_q, i_done_d;   // fetch part of this CPU cycle finished
   logic [31:0] instr_q, instr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic              w_data_req;
   logic              w_any_req;
   logic              w_timer_en;
   logic              w_timer_clr;
   logic              w_expire;
   logic              w_access_end;   // access completed or aborted this cycle
   logic [ADDR_W-1:0] w_data_waddr;
   logic [ADDR_W-1:0] w_instr_waddr;

   assign w_data_req = data_read | (data_write != 4'b0000);
   assign w_any_req  = w_data_req | instr_read;

   assign w_data_waddr  = ADDR_W'(word_align(ADDR_MAX_W'(data_addr)));
   assign w_instr_waddr = ADDR_W'(word_align(ADDR_MAX_W'(instr_addr)));

   // Stall is gated by reset so every output reads zero while rst is low,
   // even if the core keeps its request asserted.
   assign cpu_stall = rst & w_any_req & (state_q != ST_DONE);

   assign instr_out = instr_q;
   assign data_out  = data_q;
   assign bus_err   = err_q;

   // Watchdog restarts in IDLE/DONE, so every access starts from zero
   assign w_timer_en  = (state_q == ST_DATA) || (state_q == ST_INSTR);
   assign w_timer_clr = ~w_timer_en;

   mem_bridge_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (w_timer_clr),
      .en_i     (w_timer_en),
      .expire_o (w_expire)
   );

   // Next-state, memory strobes and capture values
   always_comb begin
      state_d      = state_q;
      d_done_d     = d_done_q;
      i_done_d     = i_done_q;
      instr_d      = instr_q;
      data_d       = data_q;
      err_d        = err_q;
      mem_req      = 1'b0;
      mem_we       = 4'b0000;
      mem_addr     = '0;
      mem_wdata    = 32'h0;
      w_access_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_data_req && !d_done_q) begin
               state_d = ST_DATA;
            end else if (instr_read && !i_done_q) begin
               state_d = ST_INSTR;
            end else if (w_any_req) begin
               state_d = ST_DONE;
            end
         end

         ST_DATA: begin
            mem_req   = 1'b1;
            // A load takes precedence over any simultaneous byte enables
            mem_we    = data_read ? 4'b0000 : data_write;
            mem_addr  = w_data_waddr;
            mem_wdata = data_in;
            if (mem_ready) begin
               if (data_read) begin
                  data_d = mem_rdata;
               end
               d_done_d     = 1'b1;
               w_access_end = 1'b1;
               state_d      = ST_IDLE;
            end else if (w_expire) begin
               if (data_read) begin
                  data_d = ABORT_DATA;
               end
               err_d        = 1'b1;
               d_done_d     = 1'b1;
               w_access_end = 1'b1;
               state_d      = ST_IDLE;
            end
         end

         ST_INSTR: begin
            mem_req  = 1'b1;
            mem_addr = w_instr_waddr;
            if (mem_ready) begin
               instr_d      = mem_rdata;
               i_done_d     = 1'b1;
               w_access_end = 1'b1;
               state_d      = ST_IDLE;
            end else if (w_expire) begin
               instr_d      = NOP_INSTR;
               err_d        = 1'b1;
               i_done_d     = 1'b1;
               w_access_end = 1'b1;
               state_d      = ST_IDLE;
            end
         end

         ST_DONE: begin
            // Core advances this cycle; the next CPU cycle starts fresh
            d_done_d = 1'b0;
            i_done_d = 1'b0;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, completion flags, read-data and error registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         d_done_q <= 1'b0;
         i_done_q <= 1'b0;
         instr_q  <= 32'h0;
         data_q   <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         d_done_q <= d_done_d;
         i_done_q <= i_done_d;
         instr_q  <= instr_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

`ifdef MEM_BRIDGE_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_acc_q, perf_acc_d;

   assign perf_stall_cyc  = perf_stall_q;
   assign perf_access_cnt = perf_acc_q;

   // Free-running event counters, wrapping naturally at 2^32
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_acc_d   = perf_acc_q;
      if (cpu_stall) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (w_access_end) begin
         perf_acc_d = perf_acc_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= 32'h0;
         perf_acc_q   <= 32'h0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_acc_q   <= perf_acc_d;
      end
   end
`endif

endmodule : mem_bridge
`default_nettype wire

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Sits directly downstream of the single-cycle CPU core.
- Services the core's separate instruction-fetch and data-access requests from one single-ported, variable-latency memory.
- Serialises the two requests (data first), holds the core with a stall, and returns registered read data.
- Adds a response timeout that reports a sticky bus error.

Parameters:
ADDR_W, 32, width of byte addresses on both sides
TIMEOUT_CYC, 255, cycles a memory access may wait for mem_ready before it is aborted (1..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
instr_read  in  1  core requests an instruction fetch
instr_addr  in  ADDR_W  fetch byte address
data_read  in  1  core requests a data load
data_write  in  4  byte-lane write enables; nonzero = store
data_addr  in  ADDR_W  load/store byte address
data_in  in  32  store data, lane-aligned
instr_out  out  32  fetched instruction (registered)
data_out  out  32  loaded word (registered)
cpu_stall  out  1  core must hold its state and requests
mem_req  out  1  memory access strobe
mem_we  out  4  byte write enables to memory (0 = read)
mem_addr  out  ADDR_W  word address: byte address with [1:0] forced to 0
mem_wdata  out  32  write data to memory
mem_ready  in  1  memory completes the access this cycle
mem_rdata  in  32  read data, valid when mem_ready=1
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0, state IDLE, done flags and timeout counter cleared. Reset mid-access abandons the access immediately; mem_req drops asynchronously.
- Request definitions:
  - data_req = data_read | (data_write != 0)
  - any_req = data_req | instr_read
- States:
  - IDLE:
    - If data_req and !d_done, go to DATA.
    - Else if instr_read and !i_done, go to INSTR.
    - Else if any_req, go to DONE.
  - DATA:
    - mem_req=1.
    - mem_we=data_write, forced to 0 when data_read=1; a load wins if both are set.
    - mem_addr from data_addr; mem_wdata=data_in.
    - When mem_ready=1: capture data_out<=mem_rdata on reads only, set d_done, go to IDLE.
  - INSTR:
    - mem_req=1, mem_we=0, mem_addr from instr_addr.
    - When mem_ready=1: instr_out<=mem_rdata, set i_done, go to IDLE.
  - DONE:
    - Single cycle with cpu_stall=0.
    - Clear d_done and i_done, go to IDLE.
- cpu_stall is combinational: any_req & (state != DONE). With no requests, cpu_stall=0.
- Memory handshake:
  - mem_ready is ignored when mem_req=0.
  - Zero-wait memory (mem_ready=1 in the first cycle of mem_req) completes in that cycle.
- Minimum cost per CPU cycle:
  - Fetch only: 3 cycles (IDLE, INSTR, DONE).
  - Load/store plus fetch: 5 cycles.
- Timeout:
  - A counter runs while in DATA/INSTR and clears on state entry.
  - When it reaches TIMEOUT_CYC-1 without mem_ready: abort, set bus_err=1 (sticky until reset), and treat the access as done.
  - An aborted read captures 32'h0000_0013 (NOP) into instr_out or 32'h0 into data_out.
- The core must hold its request inputs stable while cpu_stall=1. Input changes mid-access are not tracked; the latched state governs.

Optional Feature:
MEM_BRIDGE_PERF_EN
- Defined:
  - Adds outputs perf_stall_cyc[31:0] and perf_access_cnt[31:0], reset to 0.
  - perf_stall_cyc increments every cycle cpu_stall=1.
  - perf_access_cnt increments on each completed or aborted memory access.
  - Both counters wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_bridge_pkg holds:
  - State enum: IDLE, DATA, INSTR, DONE.
  - Constants NOP_INSTR=32'h0000_0013 and ABORT_DATA=32'h0.
  - A function to word-align an address.
- One sub-module is natural: mem_bridge_timer (load/clear/expire counter sized from TIMEOUT_CYC).

Test Plan:
- Fetch only, mem_ready on the 2nd mem_req cycle, mem_rdata=32'h00500093 → instr_out=32'h00500093, cpu_stall low for exactly 1 cycle, mem_we=0 throughout.
- Store data_write=4'b0011, data_addr=32'h102, data_in=32'hAAAA_BBBB, then fetch → data access first: mem_addr=32'h100, mem_we=4'b0011; then fetch issued; total 5 cycles; data_out unchanged.
- Load data_read=1, mem_rdata=32'h1234_5678, zero-wait memory → data_out=32'h1234_5678; DATA and INSTR each last 1 cycle.
- TIMEOUT_CYC=4, mem_ready held 0 → abort after 4 cycles, instr_out=32'h0000_0013, bus_err=1 and still 1 after later successful accesses.
- Assert rst low mid-DATA → all outputs 0 immediately, state IDLE; after release, the held request is re-serviced from scratch.
- With MEM_BRIDGE_PERF_EN, 3 fetch-only CPU cycles at 1-wait memory → perf_access_cnt=3, perf_stall_cyc equals the total cpu_stall-high cycle count.
